// File: rtl/arith_seq_pkg.sv
// Shared definitions for the sequential arithmetic blocks (divider side).
// Holds the observable state encoding, the state-port width and the
// default operand widths. The multiplier's own definitions live elsewhere.
package arith_seq_pkg;

  localparam int unsigned STATE_W        = 4;
  localparam int unsigned DIVIDEND_W_DEF = 8;
  localparam int unsigned DIVISOR_W_DEF  = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 4'd0,
    ST_ITER = 4'd1,
    ST_END  = 4'd2
  } state_e;

endpackage

// File: rtl/divider_controller.sv
// Divider sequencing FSM and iteration counter.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   ena           start request, honoured only in ST_IDLE
//   div_zero      current divisor input is zero
//   state         registered FSM state, zero-extended to STATE_W
//   load_c        start accepted this cycle (capture operands)
//   step_c        one restoring step this cycle
//   finish_c      result publish cycle
module divider_controller
  import arith_seq_pkg::*;
#(
  parameter int unsigned STEPS = DIVIDEND_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               div_zero,
  output logic [STATE_W-1:0] state,
  output logic               load_c,
  output logic               step_c,
  output logic               finish_c
);

  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Iteration counter: loaded on a real start, counts down to 0 and parks there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_c && !div_zero) begin
      cnt_q <= CNT_W'(STEPS - 1);
    end else if (step_c && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Next-state logic; unknown encodings fall back to idle
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: if (ena) state_d = div_zero ? ST_END : ST_ITER;
      ST_ITER: state_d = (cnt_q == '0) ? ST_END : ST_ITER;
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decoded from the current state
  always_comb begin
    load_c   = 1'b0;
    step_c   = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      ST_IDLE: load_c   = ena;
      ST_ITER: step_c   = 1'b1;
      ST_END:  finish_c = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/four_bit_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   ena        start request (ST_IDLE only)
//   N, D       dividend / divisor, captured on the start edge
//   Q, R       registered quotient / remainder of the last division
//   dbz        registered divide-by-zero flag of the last division
//   done       registered one-cycle completion pulse
//   state      FSM state (0 idle, 1 iterate, 2 end)
module four_bit_divider
  import arith_seq_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [DIVIDEND_W-1:0] N,
  input  logic [DIVISOR_W-1:0]  D,
  output logic [DIVIDEND_W-1:0] Q,
  output logic [DIVISOR_W-1:0]  R,
  output logic                  dbz,
  output logic                  done,
  output logic [STATE_W-1:0]    state
);

  logic [DIVIDEND_W-1:0] quo;
  logic [DIVISOR_W-1:0]  rem;
  logic [DIVISOR_W-1:0]  div;
  logic                  dbz_flag;
  logic                  div_zero_c;
  logic                  load_c;
  logic                  step_c;
  logic                  finish_c;
  logic [DIVISOR_W:0]    shifted_c;
  logic [DIVISOR_W:0]    trial_c;

  divider_controller #(
    .STEPS (DIVIDEND_W)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .div_zero (div_zero_c),
    .state    (state),
    .load_c   (load_c),
    .step_c   (step_c),
    .finish_c (finish_c)
  );

  assign div_zero_c = (D == '0);

  // Trial subtraction at DIVISOR_W+1 bits; MSB set means it went negative
  always_comb begin
    shifted_c = {rem, quo[DIVIDEND_W-1]};
    trial_c   = shifted_c - {1'b0, div};
  end

  // Datapath. A kept remainder is always below the divisor, so its top bit
  // is zero and only the low DIVISOR_W bits are stored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo      <= '0;
      rem      <= '0;
      div      <= '0;
      dbz_flag <= 1'b0;
    end else if (load_c) begin
      quo      <= N;
      rem      <= '0;
      div      <= D;
      dbz_flag <= div_zero_c;
    end else if (step_c) begin
      if (!trial_c[DIVISOR_W]) begin
        rem <= trial_c[DIVISOR_W-1:0];
        quo <= {quo[DIVIDEND_W-2:0], 1'b1};
      end else begin
        rem <= shifted_c[DIVISOR_W-1:0];
        quo <= {quo[DIVIDEND_W-2:0], 1'b0};
      end
    end
  end

  // Result registers update only in the end cycle; done pulses with them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Q    <= '0;
      R    <= '0;
      dbz  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= finish_c;
      if (finish_c) begin
        Q   <= dbz_flag ? '1 : quo;
        R   <= dbz_flag ? '0 : rem;
        dbz <= dbz_flag;
      end
    end
  end

endmodule

// File: tb/tb_four_bit_divider.sv
// Directed bench for four_bit_divider: a cycle-timeline model built from
// plain integer division, checked every falling edge, plus literal results.
module tb_four_bit_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] N   = 8'd0;
  logic [3:0] D   = 4'd0;
  logic [7:0] Q;
  logic [3:0] R;
  logic       dbz;
  logic       done;
  logic [3:0] state;

  int n_vec = 0;
  int n_bad = 0;

  four_bit_divider dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .N     (N),
    .D     (D),
    .Q     (Q),
    .R     (R),
    .dbz   (dbz),
    .done  (done),
    .state (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a start costs 9 edges (1 for a zero divisor), then the
  // results are plain N/D and N%D.
  bit m_busy  = 1'b0;
  int m_k     = 0;
  int m_len   = 0;
  int m_n     = 0;
  int m_d     = 0;
  int e_q     = 0;
  int e_r     = 0;
  int e_dbz   = 0;
  int e_done  = 0;
  int e_state = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_k <= 0; m_len <= 0; m_n <= 0; m_d <= 0;
      e_q <= 0; e_r <= 0; e_dbz <= 0; e_done <= 0; e_state <= 0;
    end else begin
      e_done <= 0;
      if (!m_busy) begin
        if (ena) begin
          m_busy  <= 1'b1;
          m_k     <= 0;
          m_n     <= int'(N);
          m_d     <= int'(D);
          m_len   <= (D == 4'd0) ? 1 : 9;
          e_state <= (D == 4'd0) ? 2 : 1;
        end else begin
          e_state <= 0;
        end
      end else begin
        m_k <= m_k + 1;
        if (m_k + 1 == m_len) begin
          m_busy  <= 1'b0;
          e_state <= 0;
          e_done  <= 1;
          if (m_d == 0) begin
            e_q <= 255; e_r <= 0; e_dbz <= 1;
          end else begin
            e_q <= m_n / m_d; e_r <= m_n % m_d; e_dbz <= 0;
          end
        end else if (m_k + 2 == m_len) begin
          e_state <= 2;
        end else begin
          e_state <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_Q",     int'(Q),     e_q);
    chk("model_R",     int'(R),     e_r);
    chk("model_dbz",   int'(dbz),   e_dbz);
    chk("model_done",  int'(done),  e_done);
    chk("model_state", int'(state), e_state);
  end

  // One division with ena pulsed for a single cycle; checks latency and result
  task automatic run_div(input int n, input int d, input int eq, input int er,
                         input int edz, input int elat, input bit chk_seq);
    int lat;
    int exp_st;
    @(negedge clk); #2;
    N = 8'(n); D = 4'(d); ena = 1'b1;
    @(posedge clk); #1;
    ena = 1'b0;
    lat = 0;
    if (chk_seq) chk("seq_state0", int'(state), 1);
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (chk_seq) begin
        exp_st = (lat < 8) ? 1 : ((lat == 8) ? 2 : 0);
        chk("seq_state", int'(state), exp_st);
      end
    end
    chk("latency", lat, elat);
    chk("lit_Q",   int'(Q),   eq);
    chk("lit_R",   int'(R),   er);
    chk("lit_dbz", int'(dbz), edz);
  endtask

  // ena held high; operands and ena scrambled while iterating
  task automatic back_to_back();
    int ns[3] = '{200, 250, 17};
    int ds[3] = '{7, 11, 3};
    int eq[3] = '{28, 22, 5};
    int er[3] = '{4, 8, 2};
    int edge_cnt;
    int last;
    int lat;
    edge_cnt = 0;
    last     = 0;
    @(negedge clk); #2;
    N = 8'(ns[0]); D = 4'(ds[0]); ena = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lat = 0;
      do begin
        @(posedge clk); #1;
        edge_cnt++;
        lat++;
        if (state == 4'd1) begin
          N   = 8'($urandom);
          D   = 4'($urandom);
          ena = 1'($urandom);
        end
      end while (!done && lat < 30);
      chk("b2b_Q", int'(Q), eq[i]);
      chk("b2b_R", int'(R), er[i]);
      if (i > 0) chk("b2b_period", edge_cnt - last, 10);
      last = edge_cnt;
      if (i < 2) begin
        N = 8'(ns[i+1]); D = 4'(ds[i+1]); ena = 1'b1;
      end else begin
        ena = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_Q",     int'(Q),     0);
    chk("rst_R",     int'(R),     0);
    chk("rst_dbz",   int'(dbz),   0);
    chk("rst_done",  int'(done),  0);
    chk("rst_state", int'(state), 0);
    #1;
    rst = 1'b1;

    run_div(200, 7, 28, 4, 0, 9, 1'b1);
    run_div(255, 1, 255, 0, 0, 9, 1'b0);
    run_div(255, 15, 17, 0, 0, 9, 1'b0);
    run_div(5, 9, 0, 5, 0, 9, 1'b0);
    run_div(0, 3, 0, 0, 0, 9, 1'b0);
    run_div(42, 0, 255, 0, 1, 1, 1'b0);
    run_div(42, 6, 7, 0, 0, 9, 1'b0);

    back_to_back();

    // Abort a division with reset between t3 and t4
    @(negedge clk); #2;
    N = 8'd77; D = 4'd5; ena = 1'b1;
    @(posedge clk); #1;
    ena = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("abort_Q",     int'(Q),     0);
    chk("abort_R",     int'(R),     0);
    chk("abort_dbz",   int'(dbz),   0);
    chk("abort_done",  int'(done),  0);
    chk("abort_state", int'(state), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_hold_done", int'(done), 0);
    end
    @(negedge clk); #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", int'(state), 0);
    end
    run_div(100, 10, 10, 0, 0, 9, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/four_bit_divider.md
# four_bit_divider

Sequential restoring divider: 8-bit unsigned dividend by 4-bit unsigned divisor, one quotient bit per clock. Produces an 8-bit quotient, a 4-bit remainder and a divide-by-zero flag, with the same start/done handshake and state-observation port as the team's 4-bit shift-add multiplier. It is the inverse arithmetic block in the same sequential-arithmetic datapath and sits beside the multiplier on the same bus.

## Interface
- DIVIDEND_W, 8, dividend and quotient width
- DIVISOR_W, 4, divisor and remainder width
- clk  in  1  single clock, rising edge
- rst  in  1  reset: asynchronous, active-low; all state and outputs clear immediately on assertion
- ena  in  1  start request; sampled only in ST_IDLE
- N  in  DIVIDEND_W  dividend, captured on the start edge
- D  in  DIVISOR_W  divisor, captured on the start edge
- Q  out  DIVIDEND_W  quotient, registered
- R  out  DIVISOR_W  remainder, registered
- dbz  out  1  divide-by-zero flag for the last result, registered
- done  out  1  one-cycle completion pulse, registered
- state  out  4  current FSM state, zero-extended: ST_IDLE=0, ST_ITER=1, ST_END=2

## Operation
- ST_IDLE:
  - On ena=1 with D≠0: capture N into the quotient shift register and D into the divisor register, clear the partial remainder (DIVISOR_W+1 bits), load the iteration counter with DIVIDEND_W-1, go to ST_ITER.
  - On ena=1 with D=0: set the internal dbz flag and go directly to ST_END.
  - Otherwise stay in ST_IDLE.
- ST_ITER, one step per cycle:
  - trial = {rem[DIVISOR_W-1:0], quo[MSB]} − {0, D}, computed at DIVISOR_W+1 bits.
  - If trial is non-negative (MSB=0): rem←trial and quo←{quo[MSB-1:0],1}.
  - Else: rem←{rem[DIVISOR_W-1:0], quo[MSB]} and quo←{quo[MSB-1:0],0}.
  - Decrement the counter. The step taken when the counter equals 0 is the last one; then go to ST_END.
- ST_END:
  - Load Q←quo and R←rem[DIVISOR_W-1:0]. If dbz is set, load Q←all ones and R←0 instead.
  - Load the dbz output, assert done, go to ST_IDLE.
- Q, R and dbz hold until the next ST_END. done is 0 in every other cycle.
- ena in ST_ITER or ST_END is ignored. There is no queueing.
- Undefined state encodings return to ST_IDLE with done=0.

## Timing
- Reset values: Q=0, R=0, dbz=0, done=0, state=0, all internal registers 0.
- Start edge t0 (ST_IDLE, ena=1, D≠0):
  - ST_ITER occupies edges t1..t8.
  - Edge t9 is the ST_END→ST_IDLE transition; outputs update and done is high after t9.
  - Latency from the start edge to done: 9 edges.
- Divide by zero: ST_END is entered at t0 and done is high after t1.
- Back-to-back operation: with ena held high, the next start is accepted at the edge after done rises, in ST_IDLE. The minimum period is 10 cycles.
- Reset asserted mid-operation aborts immediately. No done pulse is produced. After release the block sits in ST_IDLE.
- Operand changes after t0 have no effect on the running division.

## Structure
- Shared package arith_seq_pkg:
  - state constants ST_IDLE, ST_ITER, ST_END
  - the 4-bit state-output width
  - default operand widths
- The multiplier's state defines stay untouched. The new package is additive.
- One sub-module, divider_controller:
  - owns the FSM and the iteration counter
  - outputs state, a load strobe, a step strobe and a finish strobe
- Top level holds the datapath registers and the output registers.

## Test plan
- N=200, D=7, ena one cycle → done 9 edges after start, Q=28, R=4, dbz=0, state sequence 0,1×8,2,0.
- N=255, D=1 → Q=255, R=0. Then N=255, D=15 → Q=17, R=0.
- N=5, D=9 → Q=0, R=5. Then N=0, D=3 → Q=0, R=0.
- N=42, D=0 → done 1 edge after start, dbz=1, Q=8'hFF, R=0. A following N=42, D=6 gives Q=7, R=0, dbz=0.
- ena held high, operands changed after each start → results match the captured operands, starts 10 cycles apart, and ena/operand toggling during ST_ITER has no effect.
- rst low at edge t4 of a division → all outputs 0 at once, no done. After release, N=100, D=10 gives Q=10, R=0.
